regfile_hs: RTL and testbench

- Multi-entry register bank built from enable-style write storage.
- Provides the read side that the datapath and debug logic need.
- Single always-accepted write port; valid/ready read-request channel; registered, backpressurable response channel.
- DUMP mode streams every entry in address order over the response channel for debug readback.

---
 rtl/regfile_hs_if.sv | 23 ++
 rtl/regfile_hs.sv | 60 ++++++
 tb/tb_regfile_hs.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_hs_if.sv
// regfile_hs_if: write, read-request, dump-control and response signals of regfile_hs
interface regfile_hs_if #(parameter int WIDTH = 16, parameter int AW = 3);
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [AW-1:0]    rd_addr;
  logic             dump_start;
  logic             dump_busy;
  logic             rd_resp_valid;
  logic             rd_resp_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_resp_last;
  modport master (
    output wr_en, wr_addr, wr_data, rd_req_valid, rd_addr, dump_start, rd_resp_ready,
    input  rd_req_ready, dump_busy, rd_resp_valid, rd_data, rd_resp_last
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req_valid, rd_addr, dump_start, rd_resp_ready,
    output rd_req_ready, dump_busy, rd_resp_valid, rd_data, rd_resp_last
  );
endinterface

// File: rtl/regfile_hs.sv
// regfile_hs: register bank with handshaked reads, write forwarding and full-bank dump
module regfile_hs #(
  parameter int WIDTH = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 8
) (
  input logic         clock,
  input logic         resetn,
  regfile_hs_if.slave bus
);
  typedef enum logic {IDLE, DUMP} state_t;
  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      cnt;
  logic             valid, last;
  logic [WIDTH-1:0] data;
  logic             free, accept, issue;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdat;
  assign free             = !valid || bus.rd_resp_ready;
  assign bus.rd_req_ready = state == IDLE && free && !bus.dump_start;
  assign accept           = bus.rd_req_valid && bus.rd_req_ready;
  // cnt has an extra bit so the dump stops after the final entry instead of wrapping
  assign issue            = state == DUMP && free && !cnt[AW];
  assign raddr            = state == DUMP ? cnt[AW-1:0] : bus.rd_addr;
  assign rdat             = bus.wr_en && bus.wr_addr == raddr ? bus.wr_data : mem[raddr];
  assign bus.rd_resp_valid = valid;
  assign bus.rd_data       = data;
  assign bus.rd_resp_last  = last;
  assign bus.dump_busy     = state == DUMP;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state <= IDLE;
      cnt   <= '0;
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else begin
      if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
      if (accept || issue) begin
        valid <= 1'b1;
        data  <= rdat;
        last  <= issue && &cnt[AW-1:0];
      end else if (bus.rd_resp_ready) begin
        valid <= 1'b0;
        last  <= 1'b0;
      end
      if (state == IDLE) begin
        if (bus.dump_start) begin
          state <= DUMP;
          cnt   <= '0;
        end
      end else begin
        if (issue) cnt <= cnt + 1'b1;
        if (valid && bus.rd_resp_ready && last) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_regfile_hs.sv
// tb_regfile_hs: directed self-checking bench for regfile_hs
module tb_regfile_hs;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  regfile_hs_if #(.WIDTH(16), .AW(3)) bus ();
  regfile_hs #(.WIDTH(16), .AW(3), .DEPTH(8)) dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.rd_req_valid = 0; bus.rd_addr = 0; bus.dump_start = 0; bus.rd_resp_ready = 1;
    resetn = 1'b0;
    #12;
    checks++;
    if ({bus.rd_resp_valid, bus.rd_data, bus.rd_resp_last, bus.dump_busy} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b busy=%b, want all 0",
               bus.rd_resp_valid, bus.rd_data, bus.rd_resp_last, bus.dump_busy);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (bus.rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready: got %b want 1", bus.rd_req_ready);
    end
  endtask

  task automatic test_basic_read();
    wr(3, 16'hBEEF);
    bus.rd_req_valid = 1; bus.rd_addr = 3;
    tick();
    checks++;
    if (bus.rd_resp_valid !== 1'b1 || bus.rd_data !== 16'hBEEF || bus.rd_resp_last !== 1'b0) begin
      errors++;
      $display("FAIL read_addr3: got valid=%b data=%h last=%b, want 1 beef 0",
               bus.rd_resp_valid, bus.rd_data, bus.rd_resp_last);
    end
    bus.rd_addr = 5;
    tick();
    bus.rd_req_valid = 0;
    checks++;
    if (bus.rd_resp_valid !== 1'b1 || bus.rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL read_addr5: got valid=%b data=%h, want 1 0000", bus.rd_resp_valid, bus.rd_data);
    end
    tick();
    checks++;
    if (bus.rd_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_idle_valid: got %b want 0", bus.rd_resp_valid);
    end
  endtask

  task automatic test_forward();
    wr(2, 16'h1111);
    bus.wr_en = 1; bus.wr_addr = 2; bus.wr_data = 16'h2222;
    bus.rd_req_valid = 1; bus.rd_addr = 2;
    tick();
    bus.wr_en = 0; bus.rd_req_valid = 0;
    checks++;
    if (bus.rd_resp_valid !== 1'b1 || bus.rd_data !== 16'h2222) begin
      errors++;
      $display("FAIL forward: got valid=%b data=%h, want 1 2222", bus.rd_resp_valid, bus.rd_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    wr(1, 16'h00A5);
    bus.rd_req_valid = 1; bus.rd_addr = 1; bus.rd_resp_ready = 0;
    tick();
    bus.rd_req_valid = 1; bus.rd_addr = 4;
    bus.wr_en = 1; bus.wr_addr = 1; bus.wr_data = 16'h5A00;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.rd_resp_valid !== 1'b1 || bus.rd_data !== 16'h00A5 || bus.rd_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%h req_ready=%b, want 1 00a5 0",
                 i, bus.rd_resp_valid, bus.rd_data, bus.rd_req_ready);
      end
      tick();
      bus.wr_en = 0;
    end
    bus.rd_req_valid = 0; bus.rd_resp_ready = 1;
    tick();
    checks++;
    if (bus.rd_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got valid=%b want 0", bus.rd_resp_valid);
    end
    bus.rd_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp;
      exp = i == 0 ? 16'h5A00 : i == 1 ? 16'h2222 : 16'hBEEF;
      bus.rd_addr = 3'(i + 1);
      tick();
      checks++;
      if (bus.rd_resp_valid !== 1'b1 || bus.rd_data !== exp) begin
        errors++;
        $display("FAIL b2b[%0d]: got valid=%b data=%h, want 1 %h", i, bus.rd_resp_valid, bus.rd_data, exp);
      end
    end
    bus.rd_req_valid = 0;
    tick();
  endtask

  task automatic test_dump();
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h0100 + 16'(i));
    bus.dump_start = 1; bus.rd_req_valid = 1; bus.rd_addr = 0; bus.rd_resp_ready = 1;
    #1;
    checks++;
    if (bus.rd_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL dump_start_wins: got req_ready=%b want 0", bus.rd_req_ready);
    end
    tick();
    bus.dump_start = 0;
    checks++;
    if (bus.dump_busy !== 1'b1 || bus.rd_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dump_entry: got busy=%b valid=%b, want 1 0", bus.dump_busy, bus.rd_resp_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.rd_resp_valid !== 1'b1 || bus.rd_data !== 16'h0100 + 16'(i) ||
          bus.rd_resp_last !== (i == 7) || bus.dump_busy !== 1'b1 || bus.rd_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL dump_beat[%0d]: got valid=%b data=%h last=%b busy=%b req_ready=%b, want 1 %h %b 1 0",
                 i, bus.rd_resp_valid, bus.rd_data, bus.rd_resp_last, bus.dump_busy, bus.rd_req_ready,
                 16'h0100 + 16'(i), i == 7);
      end
    end
    tick();
    checks++;
    if (bus.dump_busy !== 1'b0 || bus.rd_resp_valid !== 1'b0 || bus.rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL dump_exit: got busy=%b valid=%b req_ready=%b, want 0 0 1",
               bus.dump_busy, bus.rd_resp_valid, bus.rd_req_ready);
    end
    tick();
    bus.rd_req_valid = 0;
    checks++;
    if (bus.rd_resp_valid !== 1'b1 || bus.rd_data !== 16'h0100 || bus.rd_resp_last !== 1'b0) begin
      errors++;
      $display("FAIL held_req_after_dump: got valid=%b data=%h last=%b, want 1 0100 0",
               bus.rd_resp_valid, bus.rd_data, bus.rd_resp_last);
    end
    tick();
  endtask

  task automatic test_dump_stall();
    logic [31:0] pat;
    int idx, cyc;
    pat = 32'b1011_0010_0111_0001_1010_1100_0110_0101;
    idx = 0; cyc = 0;
    bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    while (cyc < 64 && (idx < 8 || bus.dump_busy)) begin
      bus.rd_resp_ready = pat[cyc % 32];
      #1;
      if (bus.rd_resp_valid && bus.rd_resp_ready) begin
        checks++;
        if (idx > 7 || bus.rd_data !== 16'h0100 + 16'(idx) || bus.rd_resp_last !== (idx == 7)) begin
          errors++;
          $display("FAIL stall_dump_beat[%0d]: got data=%h last=%b, want %h %b",
                   idx, bus.rd_data, bus.rd_resp_last, 16'h0100 + 16'(idx), idx == 7);
        end
        idx++;
      end
      tick();
      cyc++;
    end
    bus.rd_resp_ready = 1;
    checks++;
    if (idx !== 8 || bus.dump_busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_dump_count: got beats=%0d busy=%b, want 8 0", idx, bus.dump_busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_dump();
    bus.rd_resp_ready = 1; bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.rd_data !== 16'h0103) begin
      errors++;
      $display("FAIL pre_reset_beat3: got %h want 0103", bus.rd_data);
    end
    #2 resetn = 0;
    #1;
    checks++;
    if ({bus.rd_resp_valid, bus.rd_data, bus.rd_resp_last, bus.dump_busy} !== 19'h0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b data=%h last=%b busy=%b, want all 0",
               bus.rd_resp_valid, bus.rd_data, bus.rd_resp_last, bus.dump_busy);
    end
    #10 resetn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.rd_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL residual_beat[%0d]: got valid=%b want 0", i, bus.rd_resp_valid);
      end
    end
    bus.rd_req_valid = 1;
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr = 3'(i);
      tick();
      checks++;
      if (bus.rd_resp_valid !== 1'b1 || bus.rd_data !== 16'h0000) begin
        errors++;
        $display("FAIL cleared_entry[%0d]: got valid=%b data=%h, want 1 0000", i, bus.rd_resp_valid, bus.rd_data);
      end
    end
    bus.rd_req_valid = 0;
    wr(0, 16'h0ABC);
    bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.rd_resp_valid !== 1'b1 || bus.rd_data !== (i == 0 ? 16'h0ABC : 16'h0000) ||
          bus.rd_resp_last !== (i == 7)) begin
        errors++;
        $display("FAIL redump_beat[%0d]: got valid=%b data=%h last=%b, want 1 %h %b",
                 i, bus.rd_resp_valid, bus.rd_data, bus.rd_resp_last, i == 0 ? 16'h0ABC : 16'h0000, i == 7);
      end
    end
    tick();
    checks++;
    if (bus.dump_busy !== 1'b0 || bus.rd_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL redump_exit: got busy=%b valid=%b, want 0 0", bus.dump_busy, bus.rd_resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_forward();
    test_backpressure();
    test_dump();
    test_dump_stall();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
